// File: rtl/el2_lsu_fwd_wbuf.sv
// LSU posted-store write buffer: in-order line FIFO with youngest-entry coalescing,
// byte-granular youngest-wins load forwarding and a hold-timed drain to the bus.

module el2_lsu_fwd_wbuf_lane #(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0]      hit_vec,   // index 0 = oldest entry
   input  logic [DEPTH-1:0][7:0] data_vec,
   output logic                  hit,
   output logic [7:0]            data
);
   // Later (younger) matches override earlier ones.
   always_comb begin
      hit  = 1'b0;
      data = 8'h00;
      for (int k = 0; k < DEPTH; k++) begin
         if (hit_vec[k]) begin
            hit  = 1'b1;
            data = data_vec[k];
         end
      end
   end
endmodule

module el2_lsu_fwd_wbuf #(
   parameter int DEPTH       = 4,
   parameter int NBYTES      = 8,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst_l,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [31:0]              st_addr,
   input  logic [NBYTES-1:0]        st_byteen,
   input  logic [8*NBYTES-1:0]      st_data,
   input  logic                     coalesce_disable,
   input  logic                     drain_force,
   input  logic                     ld_valid,
   input  logic [31:0]              ld_addr,
   input  logic [NBYTES-1:0]        ld_byteen,
   output logic [NBYTES-1:0]        ld_fwd_hit,
   output logic [8*NBYTES-1:0]      ld_fwd_data,
   output logic                     ld_full_hit,
   output logic                     bus_req_valid,
   input  logic                     bus_req_ready,
   output logic [31:0]              bus_req_addr,
   output logic [NBYTES-1:0]        bus_req_byteen,
   output logic [8*NBYTES-1:0]      bus_req_data,
   output logic                     wbuf_empty,
   output logic                     wbuf_full,
   output logic [$clog2(DEPTH):0]   wbuf_count,
   output logic                     pmu_coalesce
);
   localparam int OFS = $clog2(NBYTES);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int LW  = 32 - OFS;

   typedef struct packed {
      logic [LW-1:0]            line;
      logic [NBYTES-1:0]        be;
      logic [NBYTES-1:0][7:0]   data;
   } ent_t;

   typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_ISSUE} state_t;

   ent_t          ent [DEPTH];
   state_t        state, state_nxt;
   logic [3:0]    age, age_nxt;
   logic [PW-1:0] head, tail, yidx;
   logic [CW-1:0] count, count_nxt;
   logic          full_q, empty_q, pmu_q;
   logic          merge_ok, do_merge, do_alloc, pop;
   logic [LW-1:0] st_line, ld_line;
   logic          unused_ofs;

   assign st_line    = st_addr[31:OFS];
   assign ld_line    = ld_addr[31:OFS];
   assign unused_ofs = ^{st_addr[OFS-1:0], ld_addr[OFS-1:0]};
   assign yidx       = tail - PW'(1);

   // Never merge into a head that is already on the bus.
   assign merge_ok  = ~coalesce_disable & (count != '0) & (ent[yidx].line == st_line)
                    & ~((state == S_ISSUE) & (yidx == head));
   assign st_ready  = merge_ok | ~full_q;
   assign do_merge  = st_valid & st_ready & merge_ok;
   assign do_alloc  = st_valid & st_ready & ~merge_ok;
   assign pop       = (state == S_ISSUE) & bus_req_ready;
   assign count_nxt = count + CW'(do_alloc) - CW'(pop);

   always_comb begin
      state_nxt = state;
      age_nxt   = age;
      case (state)
         S_EMPTY: if (do_alloc) begin
            state_nxt = S_WAIT;
            age_nxt   = '0;
         end
         S_WAIT: begin
            age_nxt = age + 4'd1;
            if ((age == 4'(HOLD_CYCLES - 1)) || (count >= CW'(2)) || drain_force)
               state_nxt = S_ISSUE;
         end
         S_ISSUE: if (pop) begin
            age_nxt   = '0;
            state_nxt = (count_nxt != '0) ? S_WAIT : S_EMPTY;
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state   <= S_EMPTY;
         age     <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         pmu_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         age     <= age_nxt;
         count   <= count_nxt;
         full_q  <= (count_nxt == CW'(DEPTH));
         empty_q <= (count_nxt == '0);
         pmu_q   <= do_merge;
         if (pop)      head <= head + PW'(1);
         if (do_alloc) tail <= tail + PW'(1);
      end
   end

   // Payload needs no reset: occupancy is defined by head/count alone.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         ent[tail].line <= st_line;
         ent[tail].be   <= st_byteen;
         for (int b = 0; b < NBYTES; b++)
            ent[tail].data[b] <= st_byteen[b] ? st_data[8*b +: 8] : 8'h00;
      end else if (do_merge) begin
         ent[yidx].be <= ent[yidx].be | st_byteen;
         for (int b = 0; b < NBYTES; b++)
            if (st_byteen[b]) ent[yidx].data[b] <= st_data[8*b +: 8];
      end
   end

   assign bus_req_valid  = (state == S_ISSUE);
   assign bus_req_addr   = bus_req_valid ? {ent[head].line, {OFS{1'b0}}} : '0;
   assign bus_req_byteen = bus_req_valid ? ent[head].be : '0;
   assign bus_req_data   = bus_req_valid ? ent[head].data : '0;
   assign wbuf_empty     = empty_q;
   assign wbuf_full      = full_q;
   assign wbuf_count     = count;
   assign pmu_coalesce   = pmu_q;

   // Forwarding: entries re-ordered oldest-first, then one lane per byte picks the youngest.
   logic [DEPTH-1:0][NBYTES-1:0]       age_hit;
   logic [DEPTH-1:0][NBYTES-1:0][7:0]  age_data;
   logic [NBYTES-1:0][DEPTH-1:0]       lane_hit;
   logic [NBYTES-1:0][DEPTH-1:0][7:0]  lane_data;
   logic [NBYTES-1:0][7:0]             fwd_bytes;

   genvar k, b;
   generate
      for (k = 0; k < DEPTH; k++) begin : g_age
         logic [PW-1:0] idx;
         assign idx         = head + PW'(k);
         assign age_hit[k]  = (ld_valid && (count > CW'(k)) && (ent[idx].line == ld_line))
                            ? (ent[idx].be & ld_byteen) : '0;
         assign age_data[k] = ent[idx].data;
      end
      for (b = 0; b < NBYTES; b++) begin : g_lane
         for (k = 0; k < DEPTH; k++) begin : g_col
            assign lane_hit[b][k]  = age_hit[k][b];
            assign lane_data[b][k] = age_data[k][b];
         end
         el2_lsu_fwd_wbuf_lane #(.DEPTH(DEPTH)) u_lane (
            .hit_vec  (lane_hit[b]),
            .data_vec (lane_data[b]),
            .hit      (ld_fwd_hit[b]),
            .data     (fwd_bytes[b])
         );
      end
   endgenerate

   assign ld_fwd_data = fwd_bytes;
   assign ld_full_hit = ld_valid & (|ld_byteen) & ((ld_fwd_hit & ld_byteen) == ld_byteen);

endmodule
